hist_equalizer: RTL



---
 rtl/hist_equalizer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/hist_equalizer.sv
// hist_equalizer: builds a histogram-equalisation LUT from a stream of bin
// counts, then remaps one frame of pixels through it. Loads and frames
// alternate indefinitely.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   hist_valid_i/last_i    bin-count beat strobe / final-bin marker
//   hist_data_i            bin count, ascending bin order from bin 0
//   hist_ready_o           high while loading the histogram
//   pix_valid_i/last_i     input pixel strobe / final pixel of frame
//   pix_data_i             input pixel
//   pix_ready_o            high while remapping pixels
//   pix_valid_o/last_o     remapped pixel strobe / final pixel marker
//   pix_data_o             remapped pixel
//   err_o                  malformed or inconsistent histogram seen
module hist_equalizer #(
  parameter int unsigned C_DATA_WIDTH  = 8,
  parameter int unsigned C_COUNT_WIDTH = 16,
  parameter int unsigned C_LOG2_PIXELS = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     hist_valid_i,
  input  logic                     hist_last_i,
  input  logic [C_COUNT_WIDTH-1:0] hist_data_i,
  output logic                     hist_ready_o,
  input  logic                     pix_valid_i,
  input  logic                     pix_last_i,
  input  logic [C_DATA_WIDTH-1:0]  pix_data_i,
  output logic                     pix_ready_o,
  output logic                     pix_valid_o,
  output logic                     pix_last_o,
  output logic [C_DATA_WIDTH-1:0]  pix_data_o,
  output logic                     err_o
);

  localparam int unsigned W     = C_DATA_WIDTH;
  localparam int unsigned L     = C_LOG2_PIXELS;
  localparam int unsigned CdfW  = L + 1;
  localparam int unsigned Bins  = 2 ** W;
  localparam int unsigned SumW  = ((C_COUNT_WIDTH > CdfW) ? C_COUNT_WIDTH : CdfW) + 1;
  localparam int unsigned ProdW = W + L + 2;

  localparam logic [CdfW-1:0] CdfMax  = '1;
  localparam logic [CdfW-1:0] CdfFull = {1'b1, {L{1'b0}}};
  localparam logic [W-1:0]    IdxLast = '1;
  localparam logic [W-1:0]    LutMax  = '1;

  typedef enum logic [0:0] {StLoad, StMap} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    idx_q, idx_d;
  logic [CdfW-1:0] cdf_q, cdf_d;
  logic            err_q, err_d;
  logic            pix_valid_q, pix_valid_d;
  logic            pix_last_q, pix_last_d;
  logic [W-1:0]    pix_data_q, pix_data_d;

  logic [W-1:0]    lut_q [Bins];
  logic            lut_we;
  logic [W-1:0]    lut_wdata;

  logic [SumW-1:0]  cdf_sum;
  logic [CdfW-1:0]  cdf_n;
  logic [ProdW-1:0] prod;
  logic [ProdW-1:0] scaled;
  logic             pix_accept;

  // Running CDF with saturation, then scale to (2**W-1)/2**L and clamp.
  always_comb begin
    cdf_sum   = SumW'(cdf_q) + SumW'(hist_data_i);
    cdf_n     = (cdf_sum > SumW'(CdfMax)) ? CdfMax : cdf_sum[CdfW-1:0];
    prod      = (ProdW'(cdf_n) << W) - ProdW'(cdf_n);
    scaled    = prod >> L;
    lut_wdata = (scaled > ProdW'(LutMax)) ? LutMax : scaled[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cdf_d   = cdf_q;
    err_d   = err_q;
    lut_we  = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (hist_valid_i) begin
          lut_we = 1'b1;
          cdf_d  = cdf_n;
          idx_d  = idx_q + 1'b1;
          if (hist_last_i || (idx_q == IdxLast)) begin
            state_d = StMap;
            // Hold idx on the final bin so it never wraps.
            idx_d   = idx_q;
            err_d   = !(hist_last_i && (idx_q == IdxLast) && (cdf_n == CdfFull));
          end
        end
      end
      StMap: begin
        if (pix_valid_i && pix_last_i) begin
          state_d = StLoad;
          idx_d   = '0;
          cdf_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // Registered LUT lookup gives the one-cycle pixel latency.
  always_comb begin
    pix_accept  = (state_q == StMap) && pix_valid_i;
    pix_valid_d = pix_accept;
    pix_last_d  = pix_accept && pix_last_i;
    pix_data_d  = pix_accept ? lut_q[pix_data_i] : pix_data_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StLoad;
      idx_q       <= '0;
      cdf_q       <= '0;
      err_q       <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cdf_q       <= cdf_d;
      err_q       <= err_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
      pix_data_q  <= pix_data_d;
    end
  end

  // Table storage has no reset; contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (lut_we) begin
      lut_q[idx_q] <= lut_wdata;
    end
  end

  assign hist_ready_o = (state_q == StLoad);
  assign pix_ready_o  = (state_q == StMap);
  assign pix_valid_o  = pix_valid_q;
  assign pix_last_o   = pix_last_q;
  assign pix_data_o   = pix_data_q;
  assign err_o        = err_q;

endmodule
